// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch port (read-only) and the data port (read/write).
// Data wins arbitration by default; fetch wins after MAX_WAIT consecutive losses. Hung accesses time out.
module mem_port_arbiter #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                MAX_WAIT = 4,
    parameter int                TIMEOUT  = 64,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              stall,
    output logic              err
);
    // state  | meaning
    // IDLE   | sample requests and arbitrate
    // BUSY_I | fetch access held on the memory bus
    // BUSY_D | data access held on the memory bus
    // RESP   | one-cycle ready pulse to the granted requester
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    state_t              state;
    state_t              state_nxt;
    logic [TMR_W-1:0]    tmr;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                grant_i;
    logic                grant_d;
    logic                done;
    logic                tmo;
    logic                busy;
    logic [DATA_W-1:0]   rd_val;

    assign busy   = (state == BUSY_I) || (state == BUSY_D);
    assign rd_val = m_ack ? m_rdata : ERR_DATA;
    assign stall  = (if_req & ~if_ready) | (d_req & ~d_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        done      = 1'b0;
        tmo       = 1'b0;
        unique case (state)
            IDLE: begin
                if (d_req && (!if_req || (wait_cnt < WAIT_MAX))) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY_D;
                end else if (if_req) begin
                    grant_i   = 1'b1;
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                // ack wins over a timeout landing on the same cycle
                if (m_ack) begin
                    done      = 1'b1;
                    state_nxt = RESP;
                end else if (tmr == '0) begin
                    tmo       = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_en     <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_rdata <= '0;
            d_rdata  <= '0;
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            err      <= 1'b0;
            tmr      <= '0;
            wait_cnt <= '0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            if (grant_i) begin
                m_en     <= 1'b1;
                m_we     <= 1'b0;
                m_addr   <= if_addr;
                tmr      <= TMR_LOAD;
                wait_cnt <= '0;
            end
            if (grant_d) begin
                m_en    <= 1'b1;
                m_we    <= d_we;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
                tmr     <= TMR_LOAD;
                // a data grant with fetch pending implies wait_cnt is below the cap
                if (if_req) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
            if (done || tmo) begin
                m_en <= 1'b0;
                m_we <= 1'b0;
                if (state == BUSY_I) begin
                    if_ready <= 1'b1;
                    if_rdata <= rd_val;
                end else begin
                    d_ready <= 1'b1;
                    if (!m_we) begin
                        d_rdata <= rd_val;
                    end
                end
                if (tmo) begin
                    err <= 1'b1;
                end
            end else if (busy) begin
                tmr <= tmr - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model checked every cycle,
// plus literal expectations for latency, grant order, write behaviour and timeout.
module tb_mem_port_arbiter;
    localparam int MAX_WAIT = 4;
    localparam int TIMEOUT  = 64;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        m_en;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_ack = 1'b0;
    logic        stall;
    logic        err;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: phase 0 idle, 1 access in flight, 2 response cycle.
    int          ph = 0;
    int          own = 0;
    int          age = 0;
    int          lost = 0;
    logic        e_m_en = 1'b0;
    logic        e_m_we = 1'b0;
    logic        e_if_ready = 1'b0;
    logic        e_d_ready = 1'b0;
    logic        e_err = 1'b0;
    logic [31:0] e_addr = '0;
    logic [31:0] e_wdata = '0;
    logic [31:0] e_if_rdata = '0;
    logic [31:0] e_d_rdata = '0;
    logic [31:0] e_rd = '0;
    byte         mdl_gnt[$];
    byte         dut_gnt[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = 0; own = 0; age = 0; lost = 0;
            e_m_en = 0; e_m_we = 0; e_if_ready = 0; e_d_ready = 0; e_err = 0;
            e_addr = '0; e_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
        end else begin
            e_if_ready = 0;
            e_d_ready  = 0;
            case (ph)
                0: begin
                    if (d_req && !(if_req && lost >= MAX_WAIT)) begin
                        own = 2; ph = 1; age = 0;
                        e_m_we = d_we; e_addr = d_addr; e_wdata = d_wdata;
                        if (if_req) lost = (lost < MAX_WAIT) ? lost + 1 : lost;
                        mdl_gnt.push_back("D");
                    end else if (if_req) begin
                        own = 1; ph = 1; age = 0;
                        e_m_we = 0; e_addr = if_addr; lost = 0;
                        mdl_gnt.push_back("I");
                    end
                end
                1: begin
                    if (m_ack || age == TIMEOUT - 1) begin
                        e_rd = m_ack ? m_rdata : ERR_DATA;
                        if (!m_ack) e_err = 1;
                        if (own == 1) begin
                            e_if_ready = 1; e_if_rdata = e_rd;
                        end else begin
                            e_d_ready = 1;
                            if (!e_m_we) e_d_rdata = e_rd;
                        end
                        ph = 2;
                    end else begin
                        age++;
                    end
                end
                default: ph = 0;
            endcase
            e_m_en = (ph == 1);
        end
    end

    logic m_en_prev = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_en", m_en, e_m_en);
            if (e_m_en) begin
                check("m_we", m_we, e_m_we);
                check("m_addr", m_addr, e_addr);
                if (e_m_we) check("m_wdata", m_wdata, e_wdata);
            end
            check("if_ready", if_ready, e_if_ready);
            check("d_ready", d_ready, e_d_ready);
            check("if_rdata", if_rdata, e_if_rdata);
            check("d_rdata", d_rdata, e_d_rdata);
            check("err", err, e_err);
            check("stall", stall, (if_req & ~e_if_ready) | (d_req & ~e_d_ready));
            if (m_en && !m_en_prev) dut_gnt.push_back(m_addr == 32'h300 ? "D" : "I");
        end
        m_en_prev = m_en;
    end

    logic        bsy_en, bsy_we;
    logic [31:0] bsy_addr, bsy_wdata;

    // Single access from idle; ack arrives in busy cycle k+1; returns in the response cycle.
    task automatic do_access(input bit is_d, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata, input int k);
        @(posedge clk); #1;
        if (is_d) begin
            d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1; if_addr = addr;
        end
        @(posedge clk); #1;
        bsy_en = m_en; bsy_we = m_we; bsy_addr = m_addr; bsy_wdata = m_wdata;
        repeat (k) begin
            @(posedge clk); #1;
        end
        m_ack = 1; m_rdata = rdata;
        @(posedge clk); #1;
        m_ack = 0; m_rdata = '0;
        d_req = 0; if_req = 0; d_we = 0;
    endtask

    string exp_order = "DDDDIDDDDI";
    int    n_busy;
    bit    seen;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk_en = 1;
        @(negedge clk);
        check("rst_m_en", m_en, 0);
        check("rst_ready", {if_ready, d_ready}, 0);
        check("rst_err", err, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_rdata", if_rdata | d_rdata, 0);

        // reset in the middle of a data access
        @(posedge clk); #1; d_req = 1; d_we = 0; d_addr = 32'h80;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 0;
        #1;
        check("t1_m_en", m_en, 0);
        check("t1_d_ready", d_ready, 0);
        check("t1_err", err, 0);
        d_req = 0;
        @(negedge clk);
        check("t1_m_en_held", m_en, 0);
        @(posedge clk); #1; rst_n = 1;

        // minimum-latency fetch
        @(posedge clk); #1; if_req = 1; if_addr = 32'h100;
        @(negedge clk);
        check("t2_stall_c0", stall, 1);
        @(posedge clk); #1; m_ack = 1; m_rdata = 32'hE3A01005;
        @(negedge clk);
        check("t2_stall_c1", stall, 1);
        check("t2_m_addr", m_addr, 32'h100);
        check("t2_ready_c1", if_ready, 0);
        @(posedge clk); #1; m_ack = 0; m_rdata = '0;
        @(negedge clk);
        check("t2_ready_c2", if_ready, 1);
        check("t2_rdata", if_rdata, 32'hE3A01005);
        check("t2_stall_c2", stall, 0);
        @(posedge clk); #1; if_req = 0;
        @(negedge clk);
        check("t2_ready_off", if_ready, 0);

        // data read, then a write that must leave d_rdata alone
        do_access(1, 0, 32'h44, 0, 32'h12345678, 1);
        @(negedge clk);
        check("t3_rd_data", d_rdata, 32'h12345678);
        do_access(1, 1, 32'h40, 32'h55, 32'hAAAAAAAA, 3);
        @(negedge clk);
        check("t3_busy_en", bsy_en, 1);
        check("t3_busy_we", bsy_we, 1);
        check("t3_busy_addr", bsy_addr, 32'h40);
        check("t3_busy_wdata", bsy_wdata, 32'h55);
        check("t3_d_ready", d_ready, 1);
        check("t3_d_rdata", d_rdata, 32'h12345678);

        // both requesters held continuously, immediate acks
        @(posedge clk); #1;
        mdl_gnt.delete(); dut_gnt.delete();
        if_req = 1; if_addr = 32'h200;
        d_req = 1; d_we = 0; d_addr = 32'h300;
        m_ack = 1; m_rdata = 32'h0BADF00D;
        repeat (30) @(posedge clk);
        #1; if_req = 0; d_req = 0; m_ack = 0; m_rdata = '0;
        repeat (2) @(negedge clk);
        check("t4_dut_count", dut_gnt.size(), 10);
        check("t4_mdl_count", mdl_gnt.size(), 10);
        for (int i = 0; i < 10; i++) begin
            check("t4_dut_order", (i < dut_gnt.size()) ? dut_gnt[i] : 8'h0, exp_order[i]);
            check("t4_mdl_order", (i < mdl_gnt.size()) ? mdl_gnt[i] : 8'h0, exp_order[i]);
        end

        // ack on the very last busy cycle before timeout
        do_access(0, 0, 32'h600, 0, 32'hCAFEF00D, TIMEOUT - 1);
        @(negedge clk);
        check("t6_ready", if_ready, 1);
        check("t6_rdata", if_rdata, 32'hCAFEF00D);
        check("t6_err", err, 0);

        // stray ack while idle
        @(posedge clk); #1; m_ack = 1; m_rdata = 32'h77;
        repeat (3) @(posedge clk);
        #1; m_ack = 0; m_rdata = '0;
        @(negedge clk);
        check("stray_m_en", m_en, 0);
        check("stray_if_rdata", if_rdata, 32'hCAFEF00D);
        check("stray_d_rdata", d_rdata, 32'h0BADF00D);
        check("stray_err", err, 0);

        // no ack at all: timeout
        @(posedge clk); #1; if_req = 1; if_addr = 32'h500;
        n_busy = 0; seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (m_en) n_busy++;
            if (if_ready) seen = 1;
        end
        check("t5_ready_seen", seen, 1);
        check("t5_busy_cycles", n_busy, TIMEOUT);
        check("t5_rdata", if_rdata, ERR_DATA);
        check("t5_err", err, 1);
        @(posedge clk); #1; if_req = 0;
        repeat (4) @(negedge clk);
        check("t5_err_sticky", err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
